// File: rtl/csi2_pixel_unpacker.sv
// CSI-2 long-packet payload unpacker: RAW8/RAW10 bytes to four 10-bit pixels per beat.
// Packets of other data types, or on a filtered-out virtual channel, are dropped.
module csi2_pixel_unpacker #(
  parameter bit         VC_FILTER_ENABLE = 1'b0,
  parameter logic [1:0] VC_FILTER        = 2'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  virtual_channel,
  input  logic [15:0] word_count,
  input  logic [31:0] image_data,
  input  logic [7:0]  image_data_type,
  input  logic        image_data_enable,
  output logic [39:0] pixel_data,
  output logic        pixel_valid,
  output logic [1:0]  pixel_virtual_channel,
  output logic        pixel_line_end,
  output logic        packet_error
);

  localparam logic [7:0] DtRaw8  = 8'h2A;
  localparam logic [7:0] DtRaw10 = 8'h2B;

  typedef enum logic [1:0] {StIdle, StRaw8, StRaw10, StDiscard} state_e;

  state_e      state_q, state_d, mode;
  logic [15:0] remaining_q, remaining_d, cur_rem;
  logic [1:0]  vc_q, vc_d;
  logic [63:0] buf_q, buf_d, merged;
  logic [3:0]  count_q, count_d, sum;
  logic [2:0]  n;
  logic [31:0] masked;
  logic [39:0] group_pixels;
  logic        group_fire, pkt_end;
  logic [39:0] pixel_data_d;
  logic [1:0]  pixel_vc_d;
  logic        pixel_valid_d, line_end_d, error_d;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    vc_d          = vc_q;
    buf_d         = buf_q;
    count_d       = count_q;
    mode          = state_q;
    cur_rem       = remaining_q;
    n             = 3'd0;
    masked        = '0;
    merged        = buf_q;
    sum           = count_q;
    group_fire    = 1'b0;
    pkt_end       = 1'b0;
    group_pixels  = '0;
    pixel_data_d  = pixel_data;
    pixel_vc_d    = pixel_virtual_channel;
    pixel_valid_d = 1'b0;
    line_end_d    = 1'b0;
    error_d       = 1'b0;

    // A zero-length start word carries nothing and opens no packet.
    if (image_data_enable && !(state_q == StIdle && word_count == 16'd0)) begin
      if (state_q == StIdle) begin
        cur_rem = word_count;
        vc_d    = virtual_channel;
        if (VC_FILTER_ENABLE && virtual_channel != VC_FILTER) mode = StDiscard;
        else if (image_data_type == DtRaw8)                   mode = StRaw8;
        else if (image_data_type == DtRaw10)                  mode = StRaw10;
        else                                                  mode = StDiscard;
      end
      n           = (cur_rem >= 16'd4) ? 3'd4 : cur_rem[2:0];
      remaining_d = cur_rem - 16'(n);
      pkt_end     = (remaining_d == 16'd0);
      state_d     = pkt_end ? StIdle : mode;
      for (int b = 0; b < 4; b++) begin
        masked[8*b +: 8] = (b < int'(n)) ? image_data[8*b +: 8] : 8'h00;
      end

      if (mode != StDiscard) begin
        merged = buf_q | ({32'b0, masked} << {count_q, 3'b000});
        sum    = count_q + 4'(n);
        if (mode == StRaw8 && sum >= 4'd4) begin
          group_fire = 1'b1;
          for (int i = 0; i < 4; i++) group_pixels[10*i +: 10] = {merged[8*i +: 8], 2'b00};
          buf_d   = merged >> 32;
          count_d = sum - 4'd4;
        end else if (mode == StRaw10 && sum >= 4'd5) begin
          group_fire = 1'b1;
          for (int i = 0; i < 4; i++) begin
            group_pixels[10*i +: 10] = {merged[8*i +: 8], merged[32 + 2*i +: 2]};
          end
          buf_d   = merged >> 40;
          count_d = sum - 4'd5;
        end else begin
          buf_d   = merged;
          count_d = sum;
        end

        if (group_fire) begin
          pixel_valid_d = 1'b1;
          pixel_data_d  = group_pixels;
          pixel_vc_d    = vc_d;
        end
        if (pkt_end) begin
          if (count_d != 4'd0) begin
            error_d = 1'b1;
            buf_d   = '0;
            count_d = 4'd0;
          end else begin
            line_end_d = group_fire;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= StIdle;
      remaining_q           <= '0;
      vc_q                  <= '0;
      buf_q                 <= '0;
      count_q               <= '0;
      pixel_data            <= '0;
      pixel_valid           <= 1'b0;
      pixel_virtual_channel <= '0;
      pixel_line_end        <= 1'b0;
      packet_error          <= 1'b0;
    end else begin
      state_q               <= state_d;
      remaining_q           <= remaining_d;
      vc_q                  <= vc_d;
      buf_q                 <= buf_d;
      count_q               <= count_d;
      pixel_data            <= pixel_data_d;
      pixel_valid           <= pixel_valid_d;
      pixel_virtual_channel <= pixel_vc_d;
      pixel_line_end        <= line_end_d;
      packet_error          <= error_d;
    end
  end

endmodule

// File: tb/tb_csi2_pixel_unpacker.sv
// Bench for csi2_pixel_unpacker: an unfiltered and a VC-0-filtered instance share stimulus and
// are checked every cycle against a packet-level model built from byte positions.
module tb_csi2_pixel_unpacker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  virtual_channel;
  logic [15:0] word_count;
  logic [31:0] image_data;
  logic [7:0]  image_data_type;
  logic        image_data_enable;

  logic [39:0] pd0, pd1;
  logic        pv0, pv1, le0, le1, er0, er1;
  logic [1:0]  pvc0, pvc1;

  always #5 clock = ~clock;

  csi2_pixel_unpacker u_dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .virtual_channel       (virtual_channel),
    .word_count            (word_count),
    .image_data            (image_data),
    .image_data_type       (image_data_type),
    .image_data_enable     (image_data_enable),
    .pixel_data            (pd0),
    .pixel_valid           (pv0),
    .pixel_virtual_channel (pvc0),
    .pixel_line_end        (le0),
    .packet_error          (er0)
  );

  csi2_pixel_unpacker #(
    .VC_FILTER_ENABLE (1'b1),
    .VC_FILTER        (2'd0)
  ) u_dut_filt (
    .clock                 (clock),
    .reset_n               (reset_n),
    .virtual_channel       (virtual_channel),
    .word_count            (word_count),
    .image_data            (image_data),
    .image_data_type       (image_data_type),
    .image_data_enable     (image_data_enable),
    .pixel_data            (pd1),
    .pixel_valid           (pv1),
    .pixel_virtual_channel (pvc1),
    .pixel_line_end        (le1),
    .packet_error          (er1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  pkt [$];
  logic [39:0] hold_data [2];
  logic [1:0]  hold_vc   [2];
  logic        exp_v [2];
  logic        exp_le [2];
  logic        exp_er [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, " valid0"},    64'(pv0),  64'(exp_v[0]));
    chk({step, " data0"},     64'(pd0),  64'(hold_data[0]));
    chk({step, " vc0"},       64'(pvc0), 64'(hold_vc[0]));
    chk({step, " line_end0"}, 64'(le0),  64'(exp_le[0]));
    chk({step, " error0"},    64'(er0),  64'(exp_er[0]));
    chk({step, " valid1"},    64'(pv1),  64'(exp_v[1]));
    chk({step, " data1"},     64'(pd1),  64'(hold_data[1]));
    chk({step, " vc1"},       64'(pvc1), 64'(hold_vc[1]));
    chk({step, " line_end1"}, 64'(le1),  64'(exp_le[1]));
    chk({step, " error1"},    64'(er1),  64'(exp_er[1]));
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 2; k++) begin
      exp_v[k]  = 1'b0;
      exp_le[k] = 1'b0;
      exp_er[k] = 1'b0;
    end
  endtask

  task automatic idle(input string step);
    image_data_enable = 1'b0;
    image_data        = $urandom;
    @(posedge clock); #1;
    clear_exp();
    check_all(step);
  endtask

  task automatic fill_random(input int wc);
    pkt.delete();
    for (int i = 0; i < wc; i++) pkt.push_back(8'($urandom));
  endtask

  // Drives a packet from pkt[] (first abort_after words only) and checks every output cycle.
  // Group j of size g completes on the word whose cumulative byte count first reaches (j+1)*g.
  task automatic send_packet(input string step, input logic [7:0] dt, input logic [1:0] vc,
                             input int wc, input int abort_after);
    int          nw, g, lo, hi, j;
    bit          acc [2];
    logic [31:0] word;
    logic [39:0] px;
    nw     = (wc + 3) / 4;
    g      = (dt == 8'h2B) ? 5 : 4;
    acc[0] = (dt == 8'h2A || dt == 8'h2B);
    acc[1] = acc[0] && (vc == 2'd0);
    for (int w = 0; w < nw && w < abort_after; w++) begin
      word = $urandom;
      for (int b = 0; b < 4; b++) if (4*w + b < wc) word[8*b +: 8] = pkt[4*w + b];
      image_data_enable = 1'b1;
      image_data        = word;
      image_data_type   = (w == 0) ? dt : 8'($urandom);
      virtual_channel   = (w == 0) ? vc : 2'($urandom);
      word_count        = (w == 0) ? 16'(wc) : 16'($urandom);
      @(posedge clock); #1;
      clear_exp();
      lo = 4 * w;
      hi = (4 * w + 4 < wc) ? 4 * w + 4 : wc;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          if (hi / g > lo / g) begin
            j = hi / g - 1;
            for (int i = 0; i < 4; i++) begin
              if (g == 4) px[10*i +: 10] = {pkt[j*4 + i], 2'b00};
              else        px[10*i +: 10] = {pkt[j*5 + i], pkt[j*5 + 4][2*i +: 2]};
            end
            exp_v[k]     = 1'b1;
            hold_data[k] = px;
            hold_vc[k]   = vc;
          end
          if (w == nw - 1) begin
            if (wc % g != 0) exp_er[k] = 1'b1;
            else             exp_le[k] = exp_v[k];
          end
        end
      end
      check_all(step);
    end
    image_data_enable = 1'b0;
  endtask

  initial begin
    logic [7:0] types [3];
    types = '{8'h2A, 8'h2B, 8'h1E};
    reset_n           = 1'b0;
    image_data_enable = 1'b0;
    image_data        = '0;
    image_data_type   = '0;
    virtual_channel   = '0;
    word_count        = '0;
    for (int k = 0; k < 2; k++) begin
      hold_data[k] = '0;
      hold_vc[k]   = '0;
    end
    clear_exp();
    #1;
    check_all("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle("post_reset");

    // RAW8, VC1, 8 bytes: filtered instance discards it
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_packet("raw8", 8'h2A, 2'd1, 8, 99);
    chk("raw8 last_px3", 64'(pd0[39:30]), 64'h020);
    idle("raw8_gap");

    // RAW10 two clean groups
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hE4, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE4};
    send_packet("raw10", 8'h2B, 2'd0, 10, 99);
    chk("raw10 pixels", 64'(pd0), 64'({10'h113, 10'h0CE, 10'h089, 10'h044}));
    idle("raw10_gap");

    // RAW10 with leftover bytes, then RAW8 back-to-back
    fill_random(6);
    send_packet("err", 8'h2B, 2'd0, 6, 99);
    fill_random(8);
    send_packet("after_err", 8'h2A, 2'd0, 8, 99);
    idle("err_gap");

    // Discarded type followed back-to-back by RAW8
    fill_random(12);
    send_packet("discard", 8'h1E, 2'd0, 12, 99);
    fill_random(4);
    send_packet("after_discard", 8'h2A, 2'd3, 4, 99);
    idle("discard_gap");

    // VC filter: VC2 rejected, VC0 accepted by the filtered instance
    fill_random(8);
    send_packet("vc2", 8'h2A, 2'd2, 8, 99);
    send_packet("vc0", 8'h2A, 2'd0, 8, 99);

    // Zero-length start word opens nothing
    image_data_enable = 1'b1;
    image_data_type   = 8'h2A;
    word_count        = 16'd0;
    image_data        = $urandom;
    @(posedge clock); #1;
    clear_exp();
    check_all("zero_wc");
    fill_random(5);
    send_packet("after_zero", 8'h2B, 2'd0, 5, 99);

    // Reset mid-packet, then a clean packet
    fill_random(20);
    send_packet("pre_reset", 8'h2B, 2'd0, 20, 3);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      hold_data[k] = '0;
      hold_vc[k]   = '0;
    end
    clear_exp();
    check_all("mid_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    fill_random(10);
    send_packet("post_mid_reset", 8'h2B, 2'd0, 10, 99);

    // Randomized packets with occasional gaps
    for (int p = 0; p < 40; p++) begin
      logic [7:0] dt;
      int         wc;
      dt = types[$urandom_range(0, 2)];
      wc = $urandom_range(1, 40);
      fill_random(wc);
      send_packet("rand", dt, 2'($urandom_range(0, 3)), wc, 99);
      if ($urandom_range(0, 2) == 0) idle("rand_gap");
    end
    idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2_pixel_unpacker.md
# csi2_pixel_unpacker

Receives the long-packet payload stream from the CSI-2 `camera` receiver and unpacks it into 10-bit pixels, four pixels per output beat. The receiver provides 32-bit payload words with virtual channel, data type and byte count. This block sits directly downstream of the receiver and feeds the frame buffer / ISP. It supports RAW8 (0x2A) and RAW10 (0x2B), filters by virtual channel, and discards every other data type.

## Interface
Parameters:
- `VC_FILTER_ENABLE`, default 0: when 1, packets whose virtual channel differs from `VC_FILTER` are discarded.
- `VC_FILTER`, default 2'd0: accepted virtual channel when filtering is enabled.

Ports:
- `clock`  input  1  sole clock. All logic is synchronous to its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `virtual_channel`  input  2  VC of the current packet.
- `word_count`  input  16  payload length in bytes.
- `image_data`  input  32  payload word. Byte 0, the first received, is in `[7:0]`; byte 3 is in `[31:24]`.
- `image_data_type`  input  8  CSI-2 data type.
- `image_data_enable`  input  1  the word is valid this cycle. There is no backpressure.
- `pixel_data`  output  40  four pixels. Pixel i is in `[10i+9:10i]`; pixel 0 is the earliest.
- `pixel_valid`  output  1  one-cycle pulse per 4-pixel group.
- `pixel_virtual_channel`  output  2  VC of the packet that produced `pixel_data`.
- `pixel_line_end`  output  1  qualifies `pixel_valid`; marks the last group of a cleanly-ending packet.
- `packet_error`  output  1  one-cycle pulse when a packet ends with leftover bytes.

## Operation
- **States:** IDLE, RAW8, RAW10, DISCARD.
- **Packet start (IDLE + enable):**
  - Latch `image_data_type`, `virtual_channel` and `remaining = word_count`.
  - If `word_count == 0`, ignore the word and stay in IDLE.
  - Type 0x2A → RAW8 (group size G = 4).
  - Type 0x2B → RAW10 (G = 5).
  - Any other type, or a VC rejected by the filter → DISCARD.
  - The start word is processed in the same cycle as the state transition, exactly like any later word.
- **Per enabled word:**
  - `n = min(4, remaining)` bytes are valid, taken from byte 0 upward. Bytes beyond `n` are ignored.
  - `remaining -= n`.
  - Outside DISCARD, the n bytes are appended to the byte buffer.
- **Byte buffer:** 8 bytes deep, with a 4-bit count.
  - When count + n ≥ G, the oldest G bytes form one group, which is removed; count becomes count + n − G.
  - At most one group is produced per word. After removal the count is at most 4, so the buffer cannot overflow.
- **Unpacking:**
  - RAW8: pixel i = {Bi, 2'b00}.
  - RAW10: pixel i = {Bi, B4[2i+1:2i]}.
- **Packet end (`remaining` reaches 0):**
  - Return to IDLE on the same edge.
  - If the post-group count is 0 and a group was emitted this word, assert `pixel_line_end` with it.
  - If the post-group count is nonzero, pulse `packet_error` and clear the buffer. Not applicable in DISCARD.
- **Back-to-back packets:** an enable on the cycle after a packet end is a new packet start. No idle gap is required.
- **Between packets:** enable is never high in a non-IDLE state after end, because `remaining` governs the end of every packet.
- **Reset:** asserting `reset_n` mid-packet returns the block to IDLE, clears the buffer, count and `remaining`, and drops the partial group. No error is reported.

## Timing
- **Reset values:**
  - `pixel_data` = 0
  - `pixel_valid` = 0
  - `pixel_virtual_channel` = 0
  - `pixel_line_end` = 0
  - `packet_error` = 0
- **Latency:** all outputs are registered. `pixel_valid`, `pixel_line_end` and `packet_error` assert exactly 1 cycle after the input word that completes the group or ends the packet.
- **Output hold:**
  - `pixel_data` and `pixel_virtual_channel` hold their last value when `pixel_valid` = 0.
  - `pixel_line_end` = 0 whenever `pixel_valid` = 0.
- **Throughput:** one input word per cycle, sustained indefinitely. Output is at most one group per cycle.
  - RAW10 steady state: 4 groups per 5 words, with a byte-count cycle of 4 → 3 → 2 → 1 → 0.
- **Simultaneous events:** the final group and `packet_error` may not coincide with `pixel_line_end`. When `packet_error` pulses, `pixel_line_end` is 0 even if a group is emitted on the same cycle.

## Test plan
- **RAW8:** type 0x2A, VC 1, `word_count` = 8, words 0x04030201 then 0x08070605.
  - Expect `pixel_valid` on cycles +1 and +2.
  - First group: pixels 0x004, 0x008, 0x00C, 0x010.
  - Second group: `pixel_line_end` = 1, `pixel_virtual_channel` = 1.
- **RAW10:** type 0x2B, `word_count` = 10, bytes 11 22 33 44 E4 11 22 33 44 E4 across 3 words.
  - Expect two groups, each with pixels 0x044, 0x089, 0x0CE, 0x113.
  - The second group has `pixel_line_end` = 1 and `packet_error` = 0.
- **Error:** RAW10 with `word_count` = 6.
  - Expect one group after the second word, `pixel_line_end` = 0 and a `packet_error` pulse.
  - An immediately following RAW8 packet decodes correctly.
- **Discard:** type 0x1E with `word_count` = 12, followed back-to-back by RAW8 `word_count` = 4.
  - Expect no output for 3 words, then exactly one group with `pixel_line_end` = 1.
- **VC filter:** `VC_FILTER_ENABLE` = 1, `VC_FILTER` = 0.
  - RAW8 packet on VC 2 → no output.
  - Same packet on VC 0 → output.
- **Reset mid-packet:** drop `reset_n` after word 3 of a 5-word RAW10 packet.
  - All outputs read 0.
  - A new packet then decodes from a clean buffer.
